// File: rtl/spi_pkg.sv
// Shared types and defaults for the SPI frame master and its shifter.
// Latency: n/a (declarations only).
// Backpressure: n/a (declarations only).
package spi_pkg;

    localparam int SPI_FRAME_W  = 60;
    localparam int SPI_IDLE_GAP = 2;

    typedef enum logic [1:0] {
        IDLE,
        SHIFT,
        LOAD,
        GAP
    } spi_state_t;

endpackage

// File: rtl/spi_tx_shifter.sv
// Parallel-load, shift-left frame register with a down-counting bit counter.
// Latency: load/shift take effect on the next SPI_CLK edge; last_bit is combinational from the counter.
// Backpressure: none; the caller decides when to load and when to shift.
module spi_tx_shifter
    import spi_pkg::*;
#(
    parameter int FRAME_W = SPI_FRAME_W
) (
    input  logic               SPI_CLK,
    input  logic               reset,
    input  logic               load,
    input  logic [FRAME_W-1:0] load_data,
    input  logic               shift_en,
    output logic               next_bit,
    output logic               last_bit
);

    localparam int CNT_W = $clog2(FRAME_W);

    logic [FRAME_W-1:0] sreg;
    logic [CNT_W-1:0]   bit_cnt;

    // Load a new frame, or shift one bit out per cycle until the count reaches zero.
    always_ff @(posedge SPI_CLK or negedge reset) begin
        if (!reset) begin
            sreg    <= '0;
            bit_cnt <= '0;
        end else if (load) begin
            sreg    <= load_data;
            bit_cnt <= CNT_W'(FRAME_W - 1);
        end else if (shift_en && (bit_cnt != '0)) begin
            sreg    <= sreg << 1;
            bit_cnt <= bit_cnt - CNT_W'(1);
        end
    end

    // The MSB is already on SPI_SDI, so the master needs the bit behind it.
    assign next_bit = sreg[FRAME_W-2];
    assign last_bit = (bit_cnt == '0);

endmodule

// File: rtl/spi_frame_master.sv
// SPI initiator: accepts a FRAME_W-bit word, sends it MSB-first under SPI_CSB, ends with a one-cycle SPI_LDB strobe.
// Latency: accept edge to SPI_LDB low is FRAME_W cycles; frame-to-frame minimum is FRAME_W+1+IDLE_GAP cycles.
// Backpressure: tx_ready is low from accept until the gap has elapsed; tx_valid during that time is ignored, not queued.
// Optional feature: define SPI_READBACK_EN to add SPI_SDO capture with rx_data/rx_valid.
module spi_frame_master
    import spi_pkg::*;
#(
    parameter int FRAME_W  = SPI_FRAME_W,
    parameter int IDLE_GAP = SPI_IDLE_GAP
) (
    input  logic               SPI_CLK,
    input  logic               reset,
    input  logic [FRAME_W-1:0] tx_data,
    input  logic               tx_valid,
    output logic               tx_ready,
    output logic               SPI_CSB,
    output logic               SPI_SDI,
    output logic               SPI_LDB,
    output logic               busy,
    output logic               frame_done
`ifdef SPI_READBACK_EN
    ,
    input  logic               SPI_SDO,
    output logic [FRAME_W-1:0] rx_data,
    output logic               rx_valid
`endif
);

    // The IDLE cycle in which tx_ready is already high is the last cycle of the
    // CSB-high gap, so GAP itself only lasts IDLE_GAP-1 cycles.
    localparam int GAP_W = (IDLE_GAP > 2) ? $clog2(IDLE_GAP - 1) : 1;

    spi_state_t       state;
    logic [GAP_W-1:0] gap_cnt;
    logic             accept;
    logic             next_bit;
    logic             last_bit;

`ifdef SPI_READBACK_EN
    logic [FRAME_W-1:0] rx_sreg;
`endif

    assign accept = tx_valid & tx_ready;

    spi_tx_shifter #(
        .FRAME_W (FRAME_W)
    ) u_shifter (
        .SPI_CLK   (SPI_CLK),
        .reset     (reset),
        .load      ((state == IDLE) && accept),
        .load_data (tx_data),
        .shift_en  (state == SHIFT),
        .next_bit  (next_bit),
        .last_bit  (last_bit)
    );

    // Frame sequencer: handshake, chip select, serial data, load strobe and gap timing.
    always_ff @(posedge SPI_CLK or negedge reset) begin
        if (!reset) begin
            state      <= IDLE;
            gap_cnt    <= '0;
            tx_ready   <= 1'b0;
            busy       <= 1'b0;
            SPI_CSB    <= 1'b1;
            SPI_SDI    <= 1'b0;
            SPI_LDB    <= 1'b1;
            frame_done <= 1'b0;
`ifdef SPI_READBACK_EN
            rx_sreg    <= '0;
            rx_data    <= '0;
            rx_valid   <= 1'b0;
`endif
        end else begin
            case (state)
                IDLE: begin
                    if (accept) begin
                        state    <= SHIFT;
                        SPI_CSB  <= 1'b0;
                        SPI_SDI  <= tx_data[FRAME_W-1];
                        tx_ready <= 1'b0;
                        busy     <= 1'b1;
                    end else begin
                        tx_ready <= 1'b1;
                    end
                end
                SHIFT: begin
`ifdef SPI_READBACK_EN
                    rx_sreg <= (rx_sreg << 1) | FRAME_W'(SPI_SDO);
`endif
                    if (last_bit) begin
                        state      <= LOAD;
                        SPI_CSB    <= 1'b1;
                        SPI_LDB    <= 1'b0;
                        frame_done <= 1'b1;
                        SPI_SDI    <= 1'b0;
`ifdef SPI_READBACK_EN
                        rx_data    <= (rx_sreg << 1) | FRAME_W'(SPI_SDO);
                        rx_valid   <= 1'b1;
`endif
                    end else begin
                        SPI_SDI <= next_bit;
                    end
                end
                LOAD: begin
                    SPI_LDB    <= 1'b1;
                    frame_done <= 1'b0;
`ifdef SPI_READBACK_EN
                    rx_valid   <= 1'b0;
`endif
                    if (IDLE_GAP == 1) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        state   <= GAP;
                        gap_cnt <= GAP_W'(IDLE_GAP - 2);
                    end
                end
                GAP: begin
                    if (gap_cnt == '0) begin
                        state    <= IDLE;
                        tx_ready <= 1'b1;
                        busy     <= 1'b0;
                    end else begin
                        gap_cnt <= gap_cnt - GAP_W'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: tb/tb_spi_frame_master.sv
// Directed bench for spi_frame_master: reset, single frame, back-to-back, ignored request, mid-frame reset, readback.
// Latency: expects LDB low FRAME_W cycles after accept and a 63-cycle frame pitch.
// Backpressure: host side waits on tx_ready with a bounded loop.
module tb_spi_frame_master;

    localparam int W = 60;

    logic         SPI_CLK  = 1'b0;
    logic         reset    = 1'b1;
    logic [W-1:0] tx_data  = '0;
    logic         tx_valid = 1'b0;
    logic         SPI_SDO  = 1'b0;
    logic         tx_ready;
    logic         SPI_CSB;
    logic         SPI_SDI;
    logic         SPI_LDB;
    logic         busy;
    logic         frame_done;
`ifdef SPI_READBACK_EN
    logic [W-1:0] rx_data;
    logic         rx_valid;
`endif

    int           tests = 0;
    int           fails = 0;
    int           cyc   = 0;
    logic [W-1:0] sdo_pattern = '0;

    spi_frame_master #(
        .FRAME_W  (W),
        .IDLE_GAP (2)
    ) dut (
        .SPI_CLK    (SPI_CLK),
        .reset      (reset),
        .tx_data    (tx_data),
        .tx_valid   (tx_valid),
        .tx_ready   (tx_ready),
        .SPI_CSB    (SPI_CSB),
        .SPI_SDI    (SPI_SDI),
        .SPI_LDB    (SPI_LDB),
        .busy       (busy),
        .frame_done (frame_done)
`ifdef SPI_READBACK_EN
        ,
        .SPI_SDO    (SPI_SDO),
        .rx_data    (rx_data),
        .rx_valid   (rx_valid)
`endif
    );

    always #5 SPI_CLK = ~SPI_CLK;

    always @(posedge SPI_CLK) cyc <= cyc + 1;

    // Wait for tx_ready, offer d for one edge, then present after_d; returns the cycle stamp of the accept edge.
    task automatic accept_frame(input logic [W-1:0] d, input bit hold_valid,
                                input logic [W-1:0] after_d, output int t_acc);
        int n;
        n = 0;
        @(negedge SPI_CLK);
        while (tx_ready !== 1'b1 && n < 300) begin
            @(negedge SPI_CLK);
            n++;
        end
        tests++;
        if (tx_ready !== 1'b1) begin
            fails++;
            $display("FAIL accept_wait: tx_ready=%b after %0d cycles, required 1", tx_ready, n);
        end
        tx_data  = d;
        tx_valid = 1'b1;
        @(posedge SPI_CLK);
        #1;
        t_acc = cyc;
        if (!hold_valid) tx_valid = 1'b0;
        tx_data = after_d;
        @(negedge SPI_CLK);
    endtask

    // Called at the negedge after the accept edge; records SDI for W cycles and the LDB cycle after.
    task automatic capture(input int poke_at, input logic [W-1:0] poke_dat,
                           output logic [W-1:0] bits, output int csb_bad,
                           output int ldb_early, output bit end_ok);
        csb_bad   = 0;
        ldb_early = 0;
        bits      = '0;
        for (int i = 0; i < W; i++) begin
            if (i > 0) @(negedge SPI_CLK);
            bits[W-1-i] = SPI_SDI;
            if (SPI_CSB !== 1'b0 || busy !== 1'b1 || tx_ready !== 1'b0) csb_bad++;
            if (SPI_LDB !== 1'b1 || frame_done !== 1'b0) ldb_early++;
            SPI_SDO = sdo_pattern[W-1-i];
            if (i == poke_at) begin
                tx_valid = 1'b1;
                tx_data  = poke_dat;
            end else if (i == poke_at + 1) begin
                tx_valid = 1'b0;
            end
        end
        @(negedge SPI_CLK);
        end_ok = (SPI_LDB === 1'b0 && frame_done === 1'b1 && SPI_CSB === 1'b1 && SPI_SDI === 1'b0);
    endtask

    task automatic test_reset();
        logic [5:0] obs;
        reset    = 1'b0;
        tx_valid = 1'b0;
        for (int i = 0; i < 3; i++) begin
            @(negedge SPI_CLK);
            obs = {SPI_CSB, SPI_LDB, SPI_SDI, tx_ready, busy, frame_done};
            tests++;
            if (obs !== 6'b110000) begin
                fails++;
                $display("FAIL reset_outputs[%0d]: {csb,ldb,sdi,rdy,busy,done}=%b, required 110000", i, obs);
            end
        end
        reset = 1'b1;
        #1;
        tests++;
        if (tx_ready !== 1'b0) begin
            fails++;
            $display("FAIL ready_before_edge: tx_ready=%b, required 0", tx_ready);
        end
        @(negedge SPI_CLK);
        obs = {SPI_CSB, SPI_LDB, SPI_SDI, tx_ready, busy, frame_done};
        tests++;
        if (obs !== 6'b110100) begin
            fails++;
            $display("FAIL ready_after_release: {csb,ldb,sdi,rdy,busy,done}=%b, required 110100", obs);
        end
    endtask

    task automatic test_single_frame();
        logic [W-1:0] d;
        logic [W-1:0] bits;
        int           t0;
        int           csb_bad;
        int           ldb_early;
        bit           end_ok;
        d = 60'hA5A_5A5A_5A5A_5A5A;
        accept_frame(d, 1'b0, ~d, t0);
        capture(-10, '0, bits, csb_bad, ldb_early, end_ok);
        tests++;
        if (bits !== d) begin
            fails++;
            $display("FAIL single_bits: got %h, required %h", bits, d);
        end
        tests++;
        if (csb_bad != 0) begin
            fails++;
            $display("FAIL single_csb_low: %0d bad shift cycles, required 0", csb_bad);
        end
        tests++;
        if (ldb_early != 0) begin
            fails++;
            $display("FAIL single_ldb_early: %0d early strobe cycles, required 0", ldb_early);
        end
        tests++;
        if (!end_ok) begin
            fails++;
            $display("FAIL single_ldb_cycle: ldb=%b done=%b csb=%b sdi=%b, required 0 1 1 0",
                     SPI_LDB, frame_done, SPI_CSB, SPI_SDI);
        end
        tests++;
        if (cyc - t0 != W) begin
            fails++;
            $display("FAIL single_latency: %0d cycles, required %0d", cyc - t0, W);
        end
        @(negedge SPI_CLK);
        tests++;
        if (SPI_LDB !== 1'b1 || frame_done !== 1'b0 || SPI_CSB !== 1'b1) begin
            fails++;
            $display("FAIL single_strobe_width: ldb=%b done=%b csb=%b, required 1 0 1",
                     SPI_LDB, frame_done, SPI_CSB);
        end
    endtask

    task automatic test_back_to_back();
        logic [W-1:0] bits;
        int           t1;
        int           t2;
        int           n;
        int           csb_bad;
        int           ldb_early;
        int           extra;
        bit           end_ok;
        accept_frame(60'h1, 1'b1, 60'hFFF_FFFF_FFFF_FFFF, t1);
        capture(-10, '0, bits, csb_bad, ldb_early, end_ok);
        tests++;
        if (bits !== 60'h1 || !end_ok || csb_bad != 0) begin
            fails++;
            $display("FAIL b2b_frame1: bits=%h end_ok=%b csb_bad=%0d, required %h 1 0", bits, end_ok, csb_bad, 60'h1);
        end
        n = 0;
        while (SPI_CSB !== 1'b0 && n < 20) begin
            @(negedge SPI_CLK);
            n++;
        end
        t2       = cyc;
        tx_valid = 1'b0;
        tests++;
        if (t2 - t1 != 63) begin
            fails++;
            $display("FAIL b2b_spacing: %0d cycles, required 63", t2 - t1);
        end
        capture(-10, '0, bits, csb_bad, ldb_early, end_ok);
        tests++;
        if (bits !== 60'hFFF_FFFF_FFFF_FFFF) begin
            fails++;
            $display("FAIL b2b_frame2_bits: got %h, required %h", bits, 60'hFFF_FFFF_FFFF_FFFF);
        end
        tests++;
        if (!end_ok || csb_bad != 0 || ldb_early != 0) begin
            fails++;
            $display("FAIL b2b_frame2_framing: end_ok=%b csb_bad=%0d ldb_early=%0d, required 1 0 0",
                     end_ok, csb_bad, ldb_early);
        end
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge SPI_CLK);
            if (SPI_CSB === 1'b0) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL b2b_no_third: %0d cycles with csb low, required 0", extra);
        end
    endtask

    task automatic test_ignored_request();
        logic [W-1:0] d;
        logic [W-1:0] bits;
        int           t0;
        int           csb_bad;
        int           ldb_early;
        int           extra;
        bit           end_ok;
        d = 60'h123_4567_89AB_CDEF;
        accept_frame(d, 1'b0, 60'h0, t0);
        capture(10, 60'hFED_CBA9_8765_4321, bits, csb_bad, ldb_early, end_ok);
        tx_valid = 1'b0;
        tests++;
        if (bits !== d) begin
            fails++;
            $display("FAIL ignored_bits: got %h, required %h", bits, d);
        end
        tests++;
        if (!end_ok || csb_bad != 0) begin
            fails++;
            $display("FAIL ignored_framing: end_ok=%b csb_bad=%0d, required 1 0", end_ok, csb_bad);
        end
        extra = 0;
        for (int i = 0; i < 80; i++) begin
            @(negedge SPI_CLK);
            if (SPI_CSB === 1'b0 || SPI_LDB === 1'b0) extra++;
        end
        tests++;
        if (extra != 0) begin
            fails++;
            $display("FAIL ignored_extra_frame: %0d active cycles, required 0", extra);
        end
    endtask

    task automatic test_mid_reset();
        logic [W-1:0] d;
        logic [W-1:0] bits;
        logic [4:0]   obs;
        int           t0;
        int           csb_bad;
        int           ldb_early;
        int           strobes;
        bit           end_ok;
        accept_frame(60'hC3C_3C3C_3C3C_3C3C, 1'b0, 60'h0, t0);
        for (int i = 1; i <= 30; i++) @(negedge SPI_CLK);
        reset = 1'b0;
        #1;
        obs = {SPI_CSB, SPI_LDB, SPI_SDI, tx_ready, busy};
        tests++;
        if (obs !== 5'b11000) begin
            fails++;
            $display("FAIL midreset_outputs: {csb,ldb,sdi,rdy,busy}=%b, required 11000", obs);
        end
        strobes = 0;
        for (int i = 0; i < 8; i++) begin
            @(negedge SPI_CLK);
            if (i == 2) reset = 1'b1;
            if (SPI_LDB === 1'b0 || frame_done === 1'b1) strobes++;
        end
        tests++;
        if (strobes != 0) begin
            fails++;
            $display("FAIL midreset_no_ldb: %0d strobe cycles, required 0", strobes);
        end
        d = 60'h9E3_7798_1B2C_4D5F;
        accept_frame(d, 1'b0, 60'h0, t0);
        capture(-10, '0, bits, csb_bad, ldb_early, end_ok);
        tests++;
        if (bits !== d || !end_ok || csb_bad != 0) begin
            fails++;
            $display("FAIL midreset_next_frame: bits=%h end_ok=%b csb_bad=%0d, required %h 1 0",
                     bits, end_ok, csb_bad, d);
        end
    endtask

`ifdef SPI_READBACK_EN
    task automatic test_readback();
        logic [W-1:0] bits;
        int           t0;
        int           csb_bad;
        int           ldb_early;
        bit           end_ok;
        sdo_pattern = 60'h0F0_F0F0_F0F0_F0F0;
        accept_frame(60'h555_5555_5555_5555, 1'b0, 60'h0, t0);
        capture(-10, '0, bits, csb_bad, ldb_early, end_ok);
        tests++;
        if (rx_data !== sdo_pattern || rx_valid !== 1'b1 || SPI_LDB !== 1'b0) begin
            fails++;
            $display("FAIL readback_data: rx_data=%h rx_valid=%b ldb=%b, required %h 1 0",
                     rx_data, rx_valid, SPI_LDB, sdo_pattern);
        end
        @(negedge SPI_CLK);
        tests++;
        if (rx_valid !== 1'b0) begin
            fails++;
            $display("FAIL readback_pulse: rx_valid=%b, required 0", rx_valid);
        end
        sdo_pattern = '0;
    endtask
`endif

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $display("[TB] %0d tests run, %0d failed", tests, fails + 1);
        $fatal(1, "watchdog");
    end

    initial begin
        test_reset();
        test_single_frame();
        test_back_to_back();
        test_ignored_request();
        test_mid_reset();
`ifdef SPI_READBACK_EN
        test_readback();
`endif
        $display("[TB] %0d tests run, %0d failed", tests, fails);
        $finish;
    end

endmodule
